mem_loader: RTL and testbench
=============================

# mem_loader

Program loader for the micro core. It accepts a framed byte stream over a valid/ready handshake and writes the decoded 32-bit words into the core's 8-bit-addressed memory. While a load is in progress it holds the core off. It is the writer side of the memory that the core's fetch and memory phases read. It sits between an external byte source (UART receiver or testbench) and the memory write port, and drives the hold input of phase_gen.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- HOLD_AT_RESET, 1, value of cpu_hold after reset (1 = core stays held until the first good load).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  byte source has data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts the byte this cycle.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  8  word address.
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  holds the core (phase_gen halt/hold).
- busy  out  1  frame in progress.
- done  out  1  sticky: last frame loaded and checksum OK.
- err  out  1  sticky: last frame checksum mismatch.

## Operation
- Frame format: SYNC, ADDR, CNT, CNT×4 data bytes (little-endian per word, byte0 = bits 7:0), CSUM.
- CSUM is the XOR of ADDR, CNT and all data bytes. SYNC is not included.
- A byte is accepted only on a cycle with in_valid && in_ready.
- FSM states and transitions:
  - IDLE: in_ready=1. Bytes other than SYNC_BYTE are discarded. On SYNC → ADDR, with busy=1, cpu_hold=1, done=0, err=0.
  - ADDR: in_ready=1. Latch the start address; checksum ← byte → CNT.
  - CNT: in_ready=1. Latch the word counter. CNT=0 → CSUM; otherwise → DATA with byte index 0.
  - DATA: in_ready=1. Shift the byte into the word at the current index and XOR it into the checksum. After the 4th byte → WRITE.
  - WRITE: in_ready=0; mem_we=1 for exactly one cycle, with mem_addr = current address and mem_wdata = assembled word. Then address +1 (8-bit wrap, 8'hFF → 8'h00) and counter −1. Counter reaches 0 → CSUM, else → DATA.
  - CSUM: in_ready=1. Match → done=1, cpu_hold=0. Mismatch → err=1, cpu_hold stays 1. Either way → IDLE, busy=0.
- A SYNC value appearing inside ADDR, CNT, DATA or CSUM is ordinary data; there is no resynchronisation mid-frame.
- Words already written before a checksum failure stay in memory. No rollback.
- mem_addr and mem_wdata hold their last values when mem_we=0.

## Timing
- Reset values: state IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=HOLD_AT_RESET, busy=0, done=0, err=0, checksum=0.
- Write latency: mem_we is asserted in the cycle after the 4th data byte is accepted.
- Throughput: minimum 5 cycles per word (4 accept cycles + 1 write cycle).
- Frame latency: minimum 4 + 5·CNT cycles from SYNC accept to the CSUM accept edge.
- done, err, cpu_hold and busy update on the clock edge that accepts CSUM.
- in_valid low stalls any state. There is no timeout.
- rst asserted mid-frame aborts the frame next edge and restores all reset values. A write in flight is dropped: mem_we=0 in the reset cycle.

## Structure
- micro_pkg holds SYNC_BYTE default, the state enum (IDLE, ADDR, CNT, DATA, WRITE, CSUM) and the address/word width constants (8/32), shared with memory.
- Sub-module loader_word_pack: byte-index counter plus 32-bit little-endian shift register. It takes a load strobe and a byte, and raises a full flag after 4 bytes. The FSM, checksum and address/counter logic stay in mem_loader.

## Test plan
- Single word: A5, 10, 01, 78, 56, 34, 12, CSUM=10^01^78^56^34^12 → one mem_we with addr 10, data 12345678; done=1, cpu_hold=0.
- Bad checksum: same frame with CSUM wrong → word still written at 10; err=1, done=0, cpu_hold=1.
- Address wrap: ADDR=FF, CNT=2 → writes at FF then 00, then done.
- CNT=0: A5, 20, 00, 20 → no mem_we; done=1. Leading junk bytes 00, 3C before A5 are ignored.
- Backpressure and stall: in_valid toggled every other cycle, plus mid-frame rst during DATA → no byte lost or duplicated; after rst all outputs equal their reset values; a fresh frame then loads correctly.

Source files
------------

// File: rtl/micro_pkg.sv
// Shared definitions for the micro core memory path: widths, frame marker
// and the program-loader state encoding.
package micro_pkg;

  localparam int ADDR_W = 8;
  localparam int WORD_W = 32;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CNT,
    ST_DATA,
    ST_WRITE,
    ST_CSUM
  } state_e;

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream, memory-write and status bundle of the program loader.
// master = loader side, slave = byte source / memory / core side.
interface mem_loader_if;
  import micro_pkg::*;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
  );

endinterface

// File: rtl/loader_word_pack.sv
// Little-endian byte-to-word assembler: first byte lands in bits 7:0.
// full pulses together with the load strobe that carries the 4th byte.
module loader_word_pack
  import micro_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  logic [1:0] idx_q;

  // NOTE: sequential state is assigned with non-blocking <= so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      word  <= '0;
    end else if (clear) begin
      idx_q <= '0;
    end else if (load) begin
      idx_q <= idx_q + 2'd1;
      word  <= {data, word[WORD_W-1:8]};
    end
  end

  assign full = load && (idx_q == 2'd3);

endmodule

// File: rtl/mem_loader.sv
// Program loader: decodes SYNC/ADDR/CNT/data/CSUM frames into 32-bit memory
// writes and holds the core until a frame loads with a good checksum.
module mem_loader
  import micro_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter bit         HOLD_AT_RESET = 1'b1
) (
  input logic          clk,
  input logic          rst,
  mem_loader_if.master bus
);

  state_e            state_q, state_d;
  logic              accept;
  logic              write_cycle;
  logic [ADDR_W-1:0] addr_q, last_addr_q;
  logic [7:0]        cnt_q;
  logic [7:0]        csum_q;
  logic [WORD_W-1:0] word, last_wdata_q;
  logic              word_full;
  logic              busy_q, done_q, err_q, hold_q;

  assign accept      = bus.in_valid && bus.in_ready;
  // A write still pending when reset arrives is dropped rather than issued.
  assign write_cycle = (state_q == ST_WRITE) && !rst;

  loader_word_pack u_pack (
    .clk   (clk),
    .rst   (rst),
    .clear (accept && (state_q == ST_CNT)),
    .load  (accept && (state_q == ST_DATA)),
    .data  (bus.in_data),
    .word  (word),
    .full  (word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept && (bus.in_data == SYNC_BYTE)) state_d = ST_ADDR;
      ST_ADDR:  if (accept) state_d = ST_CNT;
      ST_CNT:   if (accept) state_d = (bus.in_data == 8'd0) ? ST_CSUM : ST_DATA;
      ST_DATA:  if (word_full) state_d = ST_WRITE;
      ST_WRITE: state_d = (cnt_q == 8'd1) ? ST_CSUM : ST_DATA;
      ST_CSUM:  if (accept) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      cnt_q        <= '0;
      csum_q       <= '0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      hold_q       <= HOLD_AT_RESET;
    end else begin
      unique case (state_q)
        ST_IDLE: if (accept && (bus.in_data == SYNC_BYTE)) begin
          busy_q <= 1'b1;
          hold_q <= 1'b1;
          done_q <= 1'b0;
          err_q  <= 1'b0;
        end
        ST_ADDR: if (accept) begin
          addr_q <= bus.in_data;
          csum_q <= bus.in_data;
        end
        ST_CNT: if (accept) begin
          cnt_q  <= bus.in_data;
          csum_q <= csum_q ^ bus.in_data;
        end
        ST_DATA: if (accept) csum_q <= csum_q ^ bus.in_data;
        ST_WRITE: begin
          last_addr_q  <= addr_q;
          last_wdata_q <= word;
          addr_q       <= addr_q + ADDR_W'(1);
          cnt_q        <= cnt_q - 8'd1;
        end
        ST_CSUM: if (accept) begin
          busy_q <= 1'b0;
          if (csum_q == bus.in_data) begin
            done_q <= 1'b1;
            hold_q <= 1'b0;
          end else begin
            err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outside the write cycle the memory port shows the last word written.
  assign bus.in_ready  = (state_q != ST_WRITE);
  assign bus.mem_we    = write_cycle;
  assign bus.mem_addr  = write_cycle ? addr_q : last_addr_q;
  assign bus.mem_wdata = write_cycle ? word   : last_wdata_q;
  assign bus.cpu_hold  = hold_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed plus randomized frame bench for mem_loader with a frame-level
// reference model (expected writes and checksum derived from the byte list).
module tb_mem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mem_loader_if bus ();

  mem_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  payload[$];
  logic [39:0] got[$];
  logic [39:0] exp_w[$];

  always @(negedge clk)
    if (bus.mem_we === 1'b1) got.push_back({bus.mem_addr, bus.mem_wdata});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_mem_we"},   32'(bus.mem_we),   32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata,    32'd0);
    check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd1);
    check({tag, "_busy"},     32'(bus.busy),     32'd0);
    check({tag, "_done"},     32'(bus.done),     32'd0);
    check({tag, "_err"},      32'(bus.err),      32'd0);
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 32'(guard), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [31:0] word_of(input int k);
    return {payload[4*k+3], payload[4*k+2], payload[4*k+1], payload[4*k]};
  endfunction

  // Sends one frame built from payload and checks writes and final status.
  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] n,
                           input bit corrupt, input int gap);
    logic [7:0] cs;
    logic [7:0] wa;
    cs = a ^ n;
    foreach (payload[i]) cs = cs ^ payload[i];
    exp_w.delete();
    for (int k = 0; k < int'(n); k++) begin
      wa = a + 8'(k);
      exp_w.push_back({wa, word_of(k)});
    end
    got.delete();

    send_byte(8'hA5, gap);
    check({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    check({tag, "_clr_flags"},  32'({bus.cpu_hold, bus.done, bus.err}), 32'b100);
    send_byte(a, gap);
    send_byte(n, gap);
    for (int i = 0; i < payload.size(); i++) begin
      send_byte(payload[i], gap);
      if (i % 4 == 3) begin
        check({tag, "_we_latency"}, 32'(bus.mem_we), 32'd1);
        check({tag, "_we_data"},    bus.mem_wdata, word_of(i / 4));
      end
    end
    send_byte(corrupt ? (cs ^ 8'h5A) : cs, gap);

    check({tag, "_done"}, 32'(bus.done),     corrupt ? 32'd0 : 32'd1);
    check({tag, "_err"},  32'(bus.err),      corrupt ? 32'd1 : 32'd0);
    check({tag, "_hold"}, 32'(bus.cpu_hold), corrupt ? 32'd1 : 32'd0);
    check({tag, "_busy"}, 32'(bus.busy),     32'd0);
    check({tag, "_nwrites"}, 32'(got.size()), 32'(exp_w.size()));
    for (int k = 0; k < exp_w.size() && k < got.size(); k++) begin
      check({tag, "_waddr"}, 32'(got[k][39:32]), 32'(exp_w[k][39:32]));
      check({tag, "_wdata"}, got[k][31:0], exp_w[k][31:0]);
    end
  endtask

  initial begin
    logic [7:0] n;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Single word, good checksum.
    payload = '{8'h78, 8'h56, 8'h34, 8'h12};
    run_frame("single", 8'h10, 8'h01, 1'b0, 0);

    // Same frame, corrupted checksum: word still written, err set.
    run_frame("badcs", 8'h10, 8'h01, 1'b1, 0);

    // Address wrap across 8'hFF.
    payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'hA5, 8'hEE, 8'hDD};
    run_frame("wrap", 8'hFF, 8'h02, 1'b0, 0);

    // Junk before SYNC, then an empty frame.
    send_byte(8'h00, 0);
    send_byte(8'h3C, 0);
    check("junk_busy", 32'(bus.busy), 32'd0);
    payload.delete();
    run_frame("cnt0", 8'h20, 8'h00, 1'b0, 0);

    // in_valid toggling every other cycle.
    payload.delete();
    for (int i = 0; i < 12; i++) payload.push_back(8'($urandom));
    run_frame("stall", 8'h40, 8'h03, 1'b0, 1);

    // Mid-frame reset during DATA: first word written, frame aborted.
    got.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h30, 0);
    send_byte(8'h03, 0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hDE, 0);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    check("midrst_nwrites", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("midrst_word", got[0][31:0], 32'hDEADBEEF);
    rst = 1'b0;

    // Fresh frame after reset must assemble from byte index 0.
    payload = '{8'h0D, 8'hF0, 8'hAD, 8'h8B};
    run_frame("after_rst", 8'h30, 8'h01, 1'b0, 0);

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      n = 8'($urandom_range(1, 4));
      payload.delete();
      for (int i = 0; i < 4 * int'(n); i++) payload.push_back(8'($urandom));
      run_frame($sformatf("rand%0d", f), 8'($urandom), n,
                ($urandom_range(0, 3) == 0), int'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
